// File: rtl/maxpool_2x2_reader.sv
// 2x2/stride-2 max-pool read controller: sweeps the source memory window by window and emits
// one signed max per window. Define MAXPOOL_RELU_EN to clamp negative results to zero.
module maxpool_2x2_reader #(
  parameter int unsigned N_C        = 26,
  parameter int unsigned N_R        = 26,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ren,
  output logic [ADDR_W-1:0]     radd1,
  output logic [ADDR_W-1:0]     radd2,
  input  logic [DATA_W-1:0]     rdata0,
  input  logic [DATA_W-1:0]     rdata1,
  input  logic [DATA_W-1:0]     rdata2,
  input  logic [DATA_W-1:0]     rdata3,
  output logic                  out_valid,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0]     out_data
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(N_R - 2);
  localparam logic [ADDR_W-1:0] LastCol = ADDR_W'(N_C - 2);
  localparam logic [ADDR_W-1:0] Step    = ADDR_W'(2);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]       col_q, col_d;
  logic [OUT_ADDR_W-1:0]   idx_q, idx_d;
  logic                    drain_q, drain_d;

  // Stage-1 token: window index travelling alongside the memory's registered read.
  logic                    tok_vld_q;
  logic [OUT_ADDR_W-1:0]   tok_addr_q;

  logic                    out_valid_q;
  logic [OUT_ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]       out_data_q;

  logic signed [DATA_W-1:0] max01, max23, max_all, pooled;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    ren     = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
        end
      end
      StRead: begin
        ren   = 1'b1;
        idx_d = idx_q + 1'b1;
        if (col_q == LastCol) begin
          if (row_q == LastRow) begin
            // Last window issued: addresses hold their final values.
            state_d = StDrain;
            drain_d = 1'b0;
          end else begin
            col_d = '0;
            row_d = row_q + Step;
          end
        end else begin
          col_d = col_q + Step;
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StDone;
        end else begin
          drain_d = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    max01   = ($signed(rdata0) > $signed(rdata1)) ? $signed(rdata0) : $signed(rdata1);
    max23   = ($signed(rdata2) > $signed(rdata3)) ? $signed(rdata2) : $signed(rdata3);
    max_all = (max01 > max23) ? max01 : max23;
`ifdef MAXPOOL_RELU_EN
    pooled  = max_all[DATA_W-1] ? '0 : max_all;
`else
    pooled  = max_all;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      tok_vld_q   <= 1'b0;
      tok_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      tok_vld_q   <= ren;
      tok_addr_q  <= idx_q;
      out_valid_q <= tok_vld_q;
      if (tok_vld_q) begin
        out_addr_q <= tok_addr_q;
        out_data_q <= pooled;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign radd1     = row_q;
  assign radd2     = col_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule
